irq_priority_ctrl: RTL and testbench

- Sequential interrupt capture and service controller built around the 16-to-4 priority-encoding rule: the highest set index wins.
- Captures rising edges on 16 request lines into a pending register and applies a mask.
- Presents the highest-priority unmasked request to a servicing agent through an irq/ack/done handshake.
- Counts completed services.

---
 rtl/irq_priority_ctrl.sv | 108 ++++++++++
 tb/tb_irq_priority_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/irq_priority_ctrl.sv
// Interrupt capture and service controller.
// Rising edges on req are latched into pending. The highest unmasked pending
// index is presented on irq/irq_id. The agent answers with ack, then done,
// and each done adds one to svc_count.
module irq_priority_ctrl #(
  parameter int N   = 16,
  parameter int IDW = 4,
  parameter int CW  = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   mask,
  output logic           irq,
  output logic [IDW-1:0] irq_id,
  input  logic           ack,
  input  logic           done,
  output logic           busy,
  output logic [N-1:0]   pending,
  output logic [CW-1:0]  svc_count
);

  typedef enum logic [1:0] {IDLE, ASSERT, SERVICE} state_t;

  state_t         state, state_n;
  logic [N-1:0]   req_d;
  logic [N-1:0]   edges;
  logic [N-1:0]   cand;
  logic [N-1:0]   clr;
  logic [IDW-1:0] sel;
  logic           sel_vld;
  logic [IDW-1:0] irq_id_n;
  logic           count_en;

  assign edges = req & ~req_d;
  assign cand  = pending & ~mask;

  // Priority encoder: the highest set index of cand wins
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (cand[i]) begin
        sel     = IDW'(i);
        sel_vld = 1'b1;
      end
    end
  end

  // Next-state logic and handshake side effects
  always_comb begin
    state_n  = state;
    irq_id_n = irq_id;
    clr      = '0;
    count_en = 1'b0;
    case (state)
      IDLE: begin
        if (sel_vld) begin
          state_n  = ASSERT;
          irq_id_n = sel;
        end
      end
      ASSERT: begin
        // ack beats a mask change that arrives in the same cycle
        if (ack) begin
          state_n = SERVICE;
          clr     = N'(1) << irq_id;
        end else if (mask[irq_id]) begin
          state_n = IDLE;
        end
      end
      SERVICE: begin
        if (done) begin
          state_n  = IDLE;
          count_en = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Datapath registers: edge capture, pending, presented id, flags, counter
  always_ff @(posedge clk) begin
    if (reset) begin
      req_d     <= '0;
      pending   <= '0;
      irq_id    <= '0;
      irq       <= 1'b0;
      busy      <= 1'b0;
      svc_count <= '0;
    end else begin
      req_d   <= req;
      // A fresh edge wins over a clear of the same bit
      pending <= (pending & ~clr) | edges;
      irq_id  <= irq_id_n;
      irq     <= (state_n == ASSERT);
      busy    <= (state_n == SERVICE);
      if (count_en) svc_count <= svc_count + CW'(1);
    end
  end

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// Randomized and directed bench for irq_priority_ctrl with a behavioural model.
module tb_irq_priority_ctrl;

  localparam int N = 16;
  localparam int IDW = 4;
  localparam int CW = 8;
  localparam int S_IDLE = 0;
  localparam int S_ASSERT = 1;
  localparam int S_SVC = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   mask = '0;
  logic           ack = 1'b0;
  logic           done = 1'b0;
  logic           irq;
  logic [IDW-1:0] irq_id;
  logic           busy;
  logic [N-1:0]   pending;
  logic [CW-1:0]  svc_count;

  int total = 0;
  int bad = 0;

  // Model state
  logic [N-1:0] m_pend = '0;
  logic [N-1:0] m_reqd = '0;
  int m_state = S_IDLE;
  int m_id = 0;
  int m_count = 0;

  irq_priority_ctrl #(.N(N), .IDW(IDW), .CW(CW)) dut (
    .clk(clk), .reset(reset), .req(req), .mask(mask), .irq(irq),
    .irq_id(irq_id), .ack(ack), .done(done), .busy(busy),
    .pending(pending), .svc_count(svc_count)
  );

  always #5 clk = ~clk;

  function automatic int highest(input logic [N-1:0] v);
    int h = -1;
    for (int i = 0; i < N; i++) if (v[i]) h = i;
    return h;
  endfunction

  task automatic model_update();
    logic [N-1:0] cand;
    logic [N-1:0] nxt;
    if (reset) begin
      m_pend = '0; m_reqd = '0; m_state = S_IDLE; m_id = 0; m_count = 0;
    end else begin
      cand = m_pend & ~mask;
      nxt = m_pend;
      case (m_state)
        S_IDLE: if (cand != 0) begin m_id = highest(cand); m_state = S_ASSERT; end
        S_ASSERT: begin
          if (ack) begin nxt[m_id] = 1'b0; m_state = S_SVC; end
          else if (mask[m_id]) m_state = S_IDLE;
        end
        default: if (done) begin m_count = (m_count + 1) % 256; m_state = S_IDLE; end
      endcase
      m_pend = nxt | (req & ~m_reqd);
      m_reqd = req;
    end
  endtask

  task automatic step(input logic rs, input logic [N-1:0] rq, input logic [N-1:0] mk,
                      input logic a, input logic d);
    reset = rs; req = rq; mask = mk; ack = a; done = d;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, '0, '0, 1'b0, 1'b0);
    step(1'b1, '0, '0, 1'b0, 1'b0);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (pending !== 16'h0000) begin bad++; $display("FAIL reset_pending got=%h exp=0000", pending); end
    total++; if (svc_count !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", svc_count); end
    total++; if (irq_id !== 4'd0) begin bad++; $display("FAIL reset_id got=%0d exp=0", irq_id); end
  endtask

  task automatic test_basic();
    step(1'b0, 16'h0020, '0, 1'b0, 1'b0);
    total++; if (pending !== 16'h0020 || irq !== 1'b0) begin bad++; $display("FAIL basic_capture pending=%h irq=%b exp pending=0020 irq=0", pending, irq); end
    step(1'b0, 16'h0020, '0, 1'b0, 1'b0);
    total++; if (irq !== 1'b1 || irq_id !== 4'd5) begin bad++; $display("FAIL basic_irq irq=%b id=%0d exp irq=1 id=5", irq, irq_id); end
    step(1'b0, 16'h0020, '0, 1'b1, 1'b0);
    total++; if (pending !== 16'h0000 || busy !== 1'b1 || irq !== 1'b0) begin bad++; $display("FAIL basic_ack pending=%h busy=%b irq=%b exp 0000/1/0", pending, busy, irq); end
    step(1'b0, 16'h0020, '0, 1'b0, 1'b1);
    total++; if (busy !== 1'b0 || svc_count !== 8'd1) begin bad++; $display("FAIL basic_done busy=%b count=%0d exp busy=0 count=1", busy, svc_count); end
    step(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_priority();
    logic [CW-1:0] c0;
    int exp_ids[3] = '{14, 9, 3};
    c0 = svc_count;
    step(1'b0, 16'h4208, '0, 1'b0, 1'b0);
    total++; if (pending !== 16'h4208) begin bad++; $display("FAIL prio_pending got=%h exp=4208", pending); end
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 16'h4208, '0, 1'b0, 1'b0);
      total++; if (irq !== 1'b1 || irq_id !== IDW'(exp_ids[k])) begin bad++; $display("FAIL prio_id irq=%b id=%0d exp irq=1 id=%0d", irq, irq_id, exp_ids[k]); end
      step(1'b0, 16'h4208, '0, 1'b1, 1'b0);
      step(1'b0, 16'h4208, '0, 1'b0, 1'b1);
    end
    total++; if (svc_count !== c0 + 8'd3) begin bad++; $display("FAIL prio_count got=%0d exp=%0d", svc_count, c0 + 8'd3); end
    step(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_mask();
    step(1'b0, 16'h4004, 16'h4000, 1'b0, 1'b0);
    step(1'b0, 16'h4004, 16'h4000, 1'b0, 1'b0);
    total++; if (irq !== 1'b1 || irq_id !== 4'd2) begin bad++; $display("FAIL mask_sel irq=%b id=%0d exp irq=1 id=2", irq, irq_id); end
    step(1'b0, 16'h4004, 16'h4000, 1'b1, 1'b0);
    step(1'b0, 16'h4004, 16'h4000, 1'b0, 1'b1);
    step(1'b0, 16'h4004, 16'h0000, 1'b0, 1'b0);
    total++; if (irq !== 1'b1 || irq_id !== 4'd14) begin bad++; $display("FAIL mask_unmask irq=%b id=%0d exp irq=1 id=14", irq, irq_id); end
    step(1'b0, 16'h4004, 16'h4000, 1'b0, 1'b0);
    total++; if (irq !== 1'b0 || pending !== 16'h4000 || busy !== 1'b0) begin bad++; $display("FAIL mask_withdraw irq=%b pending=%h busy=%b exp 0/4000/0", irq, pending, busy); end
    step(1'b0, 16'h4004, 16'h4000, 1'b0, 1'b0);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL mask_hold irq=%b exp=0", irq); end
    step(1'b0, 16'h4004, 16'h0000, 1'b0, 1'b0);
    total++; if (irq !== 1'b1 || irq_id !== 4'd14) begin bad++; $display("FAIL mask_rearb irq=%b id=%0d exp irq=1 id=14", irq, irq_id); end
    step(1'b0, 16'h4004, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_collision();
    step(1'b0, 16'h0080, '0, 1'b0, 1'b0);
    step(1'b0, 16'h0000, '0, 1'b0, 1'b0);
    total++; if (irq !== 1'b1 || irq_id !== 4'd7) begin bad++; $display("FAIL coll_irq irq=%b id=%0d exp irq=1 id=7", irq, irq_id); end
    step(1'b0, 16'h0080, '0, 1'b1, 1'b0);
    total++; if (busy !== 1'b1 || pending !== 16'h0080) begin bad++; $display("FAIL coll_setwins busy=%b pending=%h exp 1/0080", busy, pending); end
    step(1'b0, 16'h0080, '0, 1'b0, 1'b1);
    step(1'b0, 16'h0080, '0, 1'b0, 1'b0);
    total++; if (irq !== 1'b1 || irq_id !== 4'd7) begin bad++; $display("FAIL coll_again irq=%b id=%0d exp irq=1 id=7", irq, irq_id); end
    step(1'b0, 16'h0000, '0, 1'b1, 1'b0);
    step(1'b0, 16'h0000, '0, 1'b0, 1'b1);
  endtask

  task automatic test_wrap_reset();
    logic [CW-1:0] c0;
    logic [CW-1:0] prev;
    bit saw_wrap = 0;
    c0 = svc_count;
    for (int s = 0; s < 256; s++) begin
      prev = svc_count;
      step(1'b0, 16'h0002, '0, 1'b0, 1'b0);
      step(1'b0, 16'h0000, '0, 1'b0, 1'b0);
      step(1'b0, 16'h0000, '0, 1'b1, 1'b0);
      step(1'b0, 16'h0000, '0, 1'b0, 1'b1);
      total++; if (svc_count !== CW'(m_count)) begin bad++; $display("FAIL wrap_count got=%0d exp=%0d", svc_count, m_count); end
      if (prev == 8'd255 && svc_count == 8'd0) saw_wrap = 1;
    end
    total++; if (!saw_wrap || svc_count !== c0) begin bad++; $display("FAIL wrap_seen wrap=%0d count=%0d exp wrap=1 count=%0d", saw_wrap, svc_count, c0); end
    step(1'b0, 16'h0080, '0, 1'b0, 1'b0);
    step(1'b0, 16'h0000, '0, 1'b0, 1'b0);
    step(1'b0, 16'h00F0, '0, 1'b1, 1'b0);
    total++; if (busy !== 1'b1 || pending !== 16'h00F0) begin bad++; $display("FAIL svc_setup busy=%b pending=%h exp 1/00f0", busy, pending); end
    step(1'b1, 16'h00F0, '0, 1'b0, 1'b0);
    total++; if (irq !== 1'b0 || busy !== 1'b0 || pending !== 16'h0000 || svc_count !== 8'd0) begin bad++; $display("FAIL svc_reset irq=%b busy=%b pending=%h count=%0d exp all 0", irq, busy, pending, svc_count); end
    step(1'b0, 16'h0000, '0, 1'b0, 1'b0);
    step(1'b0, 16'h0000, '0, 1'b0, 1'b0);
    total++; if (irq !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL reset_idle irq=%b busy=%b exp 0/0", irq, busy); end
  endtask

  task automatic test_held();
    logic [CW-1:0] c0;
    logic a;
    logic d;
    c0 = svc_count;
    for (int k = 0; k < 10; k++) begin
      a = (m_state == S_ASSERT);
      d = (m_state == S_SVC);
      step(1'b0, 16'h0001, '0, a, d);
    end
    total++; if (svc_count - c0 !== 8'd1 || pending !== 16'h0000) begin bad++; $display("FAIL held_once count_delta=%0d pending=%h exp 1/0000", svc_count - c0, pending); end
    step(1'b0, 16'h0000, '0, 1'b1, 1'b0);
    total++; if (irq !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL stray_ack irq=%b busy=%b exp 0/0", irq, busy); end
    step(1'b0, 16'h0010, '0, 1'b0, 1'b0);
    step(1'b0, 16'h0010, '0, 1'b0, 1'b0);
    step(1'b0, 16'h0010, '0, 1'b0, 1'b1);
    total++; if (irq !== 1'b1 || irq_id !== 4'd4 || busy !== 1'b0 || svc_count - c0 !== 8'd1) begin bad++; $display("FAIL stray_done irq=%b id=%0d busy=%b exp 1/4/0", irq, irq_id, busy); end
    step(1'b0, 16'h0000, '0, 1'b1, 1'b0);
    step(1'b0, 16'h0000, '0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    logic [N-1:0] rq;
    logic [N-1:0] mk;
    rq = '0;
    mk = '0;
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 2) == 0) rq = rq ^ (N'(1) << $urandom_range(0, N - 1));
      if ($urandom_range(0, 15) == 0) mk = N'($urandom & $urandom & $urandom);
      step($urandom_range(0, 300) == 0, rq, mk, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
      total++;
      if (irq !== (m_state == S_ASSERT) || busy !== (m_state == S_SVC) || irq_id !== IDW'(m_id) ||
          pending !== m_pend || svc_count !== CW'(m_count)) begin
        bad++;
        $display("FAIL rand_cycle%0d got irq=%b busy=%b id=%0d pend=%h cnt=%0d exp irq=%b busy=%b id=%0d pend=%h cnt=%0d",
                 c, irq, busy, irq_id, pending, svc_count, m_state == S_ASSERT, m_state == S_SVC,
                 m_id, m_pend, m_count);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_mask();
    test_collision();
    test_wrap_reset();
    test_held();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
